// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: size codes, responder states and the
// access-fault rule that the core's LSU applies to the same request fields.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } rsp_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } req_t;

    // limit is the first illegal byte address; 33 bits so 4*DEPTH cannot wrap
    function automatic logic access_fault(input logic [1:0]  size,
                                          input logic [31:0] addr,
                                          input logic [32:0] limit);
        return (size == SIZE_ILL) ||
               (size == SIZE_HALF && addr[0]) ||
               (size == SIZE_WORD && addr[1:0] != 2'b00) ||
               ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purpose: byte/half lane merge for stores and lane extract plus sign/zero extend for loads.
// Latency: purely combinational.
// Backpressure: none; no handshake of its own.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_dat;
    logic [15:0] half_dat;

    always_comb begin
        merged = word;
        case (size)
            SIZE_BYTE: merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            SIZE_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            SIZE_WORD: merged = wdata;
            default:   merged = word;
        endcase
    end

    assign byte_dat = 8'(word >> {lane, 3'b000});
    assign half_dat = 16'(word >> {lane[1], 4'b0000});

    always_comb begin
        rdata = word;
        case (size)
            SIZE_BYTE: rdata = {{24{~is_unsigned & byte_dat[7]}}, byte_dat};
            SIZE_HALF: rdata = {{16{~is_unsigned & half_dat[15]}}, half_dat};
            default:   rdata = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: single-outstanding load/store responder backed by word-organised storage.
// Latency: WAIT_CYCLES+1 cycles from request accept to rsp_valid.
// Backpressure: response held stable until rsp_ready; no new request accepted until idle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    logic [31:0]      mem [DEPTH_WORDS];
    rsp_state_t       state_q, state_d;
    logic [3:0]       wait_cnt_q;
    req_t             req_q;
    logic             commit;
    logic             fault;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      cur_word, merged_word, load_dat;

    assign word_idx = req_q.addr[IDX_W+1:2];
    assign cur_word = mem[word_idx];
    assign fault    = access_fault(req_q.size, req_q.addr, ADDR_LIMIT);

    dmem_lane_align u_align (
        .word        (cur_word),
        .wdata       (req_q.wdata),
        .size        (req_q.size),
        .lane        (req_q.addr[1:0]),
        .is_unsigned (req_q.is_unsigned),
        .merged      (merged_word),
        .rdata       (load_dat)
    );

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: if (i_req_valid) state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            req_q       <= '0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && i_req_valid) begin
                req_q <= '{we: i_req_we, addr: i_req_addr, size: i_req_size,
                           is_unsigned: i_req_unsigned, wdata: i_req_wdata};
                wait_cnt_q <= WAIT_INIT;
            end else if (state_q == ST_WAIT && wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
            if (commit) begin
                o_rsp_err   <= fault;
                o_rsp_rdata <= (fault || req_q.we) ? 32'd0 : load_dat;
            end
        end
    end

    // Storage is deliberately unreset; reset holds state in IDLE so no commit can fire.
    always_ff @(posedge i_clk) begin
        if (commit && req_q.we && !fault) mem[word_idx] <= merged_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: three responders (WAIT_CYCLES 1, 4, 0) checked against a byte-array model via a scoreboard.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int NDUT   = 3;
    localparam int PERIOD = 10;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic [NDUT-1:0] rst, req_valid, req_ready, req_we, req_unsigned;
    logic [NDUT-1:0] rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [1:0]  req_size  [NDUT];
    logic [31:0] rsp_rdata [NDUT];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [7:0] mdl [NDUT][4*DEPTH];
    int  vectors     = 0;
    int  miscompares = 0;
    time acc_time    = 0;

    always #(PERIOD/2) clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 0;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(wait_of(g))) u_dut (
            .i_clk          (clk),
            .i_reset        (rst[g]),
            .i_req_valid    (req_valid[g]),
            .o_req_ready    (req_ready[g]),
            .i_req_we       (req_we[g]),
            .i_req_addr     (req_addr[g]),
            .i_req_size     (req_size[g]),
            .i_req_unsigned (req_unsigned[g]),
            .i_req_wdata    (req_wdata[g]),
            .o_rsp_valid    (rsp_valid[g]),
            .i_rsp_ready    (rsp_ready[g]),
            .o_rsp_rdata    (rsp_rdata[g]),
            .o_rsp_err      (rsp_err[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (d)
            0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int pending();
        return q0.size() + q1.size() + q2.size();
    endfunction

    // Reference: memory is a flat byte array; an access touches n consecutive bytes, little-endian.
    task automatic model(input int d, input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata, output exp_t e);
        int n;
        logic [31:0] v;
        e = '0;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (size == 2'd3 || (addr % 32'(n)) != 0 || addr >= 32'(4*DEPTH)) begin
            e.err = 1'b1;
            return;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (we) mdl[d][int'(addr) + i] = wdata[8*i +: 8];
            else    v = v | (32'(mdl[d][int'(addr) + i]) << (8*i));
        end
        if (!we && !uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        if (!we) e.rdata = v;
    endtask

    task automatic drive(input int d, input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata);
        req_we[d]       = we;
        req_addr[d]     = addr;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_wdata[d]    = wdata;
        req_valid[d]    = 1'b1;
    endtask

    task automatic finish_req(input int d, input bit track, input bit use_lit, input exp_t lit);
        exp_t e;
        bit   ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = req_ready[d];
            n++;
        end
        if (!ok) begin
            check($sformatf("accept_timeout%0d", d), 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        acc_time = $time;
        #1;
        if (track) begin
            model(d, req_we[d], req_addr[d], req_size[d], req_unsigned[d], req_wdata[d], e);
            push_exp(d, use_lit ? lit : e);
        end
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'($urandom);
        req_addr[d]     = $urandom;
        req_size[d]     = 2'($urandom);
        req_unsigned[d] = 1'($urandom);
        req_wdata[d]    = $urandom;
    endtask

    task automatic issue(input int d, input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata);
        drive(d, we, addr, size, uns, wdata);
        finish_req(d, 1'b1, 1'b0, '0);
    endtask

    task automatic issue_exp(input int d, input bit we, input logic [31:0] addr, input logic [1:0] size,
                             input bit uns, input logic [31:0] wdata, input logic [31:0] xr, input bit xe);
        drive(d, we, addr, size, uns, wdata);
        finish_req(d, 1'b1, 1'b1, {xr, xe});
    endtask

    task automatic check_latency(input int d);
        for (int k = 0; k <= wait_of(d); k++) begin
            @(negedge clk);
            check($sformatf("lat_idle%0d_%0d", d, k), 32'(rsp_valid[d]), 32'd0);
        end
        @(negedge clk);
        check($sformatf("lat_valid%0d", d), 32'(rsp_valid[d]), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pending() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(pending()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        for (int d = 0; d < NDUT; d++) begin
            if (!rst[d] && rsp_valid[d] && rsp_ready[d]) begin
                pop_exp(d, e, ok);
                if (!ok) begin
                    check($sformatf("spurious_rsp%0d", d), 32'(rsp_valid[d]), 32'd0);
                end else begin
                    check($sformatf("rdata%0d", d), rsp_rdata[d], e.rdata);
                    check($sformatf("err%0d", d), 32'(rsp_err[d]), 32'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #(PERIOD*60000);
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        time t_rdy;
        time prev;
        int  n;
        rst          = '1;
        req_valid    = '0;
        req_we       = '0;
        req_unsigned = '0;
        rsp_ready    = '1;
        for (int d = 0; d < NDUT; d++) begin
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_size[d]  = 2'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("rst_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("rst_rdata%0d", d), rsp_rdata[d], 32'd0);
            check($sformatf("rst_err%0d", d), 32'(rsp_err[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = '0;

        for (int w = 0; w < DEPTH; w++) issue(0, 1'b1, 32'(w*4), SIZE_WORD, 1'b0, $urandom);
        for (int w = 0; w < DEPTH; w++) issue(2, 1'b1, 32'(w*4), SIZE_WORD, 1'b0, $urandom);
        drain();

        // Word store/load with latency check
        issue_exp(0, 1'b1, 32'h10, SIZE_WORD, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0);
        issue_exp(0, 1'b0, 32'h10, SIZE_WORD, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);
        check_latency(0);
        drain();

        // Sub-word store and extension
        issue_exp(0, 1'b1, 32'h13, SIZE_BYTE, 1'b0, 32'h0000_0080, 32'd0, 1'b0);
        issue_exp(0, 1'b0, 32'h13, SIZE_BYTE, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0);
        issue_exp(0, 1'b0, 32'h13, SIZE_BYTE, 1'b1, 32'd0, 32'h00000080, 1'b0);
        issue_exp(0, 1'b0, 32'h10, SIZE_WORD, 1'b0, 32'd0, 32'h80ADBEEF, 1'b0);
        issue_exp(0, 1'b0, 32'h12, SIZE_HALF, 1'b0, 32'd0, 32'hFFFF80AD, 1'b0);

        // Faults leave storage untouched
        issue_exp(0, 1'b0, 32'h11, SIZE_HALF, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_exp(0, 1'b0, 32'h12, SIZE_WORD, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_exp(0, 1'b0, 32'h10, SIZE_ILL, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_exp(0, 1'b1, 32'(4*DEPTH), SIZE_WORD, 1'b0, 32'h11111111, 32'd0, 1'b1);
        issue_exp(0, 1'b1, 32'h10, SIZE_ILL, 1'b0, 32'h22222222, 32'd0, 1'b1);
        issue_exp(0, 1'b1, 32'h11, SIZE_HALF, 1'b0, 32'h0000FFFF, 32'd0, 1'b1);
        issue_exp(0, 1'b1, 32'h12, SIZE_WORD, 1'b0, 32'h33333333, 32'd0, 1'b1);
        issue_exp(0, 1'b0, 32'h10, SIZE_WORD, 1'b0, 32'd0, 32'h80ADBEEF, 1'b0);
        drain();

        // Response backpressure with a second request waiting
        rsp_ready[0] = 1'b0;
        issue_exp(0, 1'b0, 32'h10, SIZE_WORD, 1'b0, 32'd0, 32'h80ADBEEF, 1'b0);
        n = 0;
        while (!rsp_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(rsp_valid[0]), 32'd1);
        drive(0, 1'b1, 32'h14, SIZE_WORD, 1'b0, 32'h55AA55AA);
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rdata_hold", rsp_rdata[0], 32'h80ADBEEF);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        t_rdy = $time;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_no_same_cycle_accept", 32'(req_ready[0]), 32'd0);
        finish_req(0, 1'b1, 1'b0, '0);
        check("bp_accept_cycle", 32'(acc_time - (t_rdy - 1)), 32'(2*PERIOD));
        issue(0, 1'b0, 32'h14, SIZE_WORD, 1'b0, 32'd0);
        drain();

        // Reset in the middle of the wait aborts an uncommitted store
        issue_exp(1, 1'b1, 32'h20, SIZE_WORD, 1'b0, 32'hCAFEF00D, 32'd0, 1'b0);
        issue_exp(1, 1'b0, 32'h20, SIZE_WORD, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0);
        check_latency(1);
        drain();
        drive(1, 1'b1, 32'h20, SIZE_WORD, 1'b0, 32'h12345678);
        finish_req(1, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready[1]), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("midrst_rdata", rsp_rdata[1], 32'd0);
        check("midrst_err", 32'(rsp_err[1]), 32'd0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        issue_exp(1, 1'b0, 32'h20, SIZE_WORD, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0);
        drain();

        // Zero-wait back-to-back loads: one accept every 3 cycles
        issue(2, 1'b0, 32'h0, SIZE_WORD, 1'b0, 32'd0);
        check_latency(2);
        drain();
        prev = 0;
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 4*DEPTH-1)) & ~((32'd1 << sz) - 32'd1);
            issue(2, 1'b0, a, sz, 1'($urandom), 32'd0);
            if (i > 0) check("b2b_interval", 32'(acc_time - prev), 32'(3*PERIOD));
            prev = acc_time;
        end
        drain();

        // Random mix with random response backpressure
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          k;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? 32'(4*DEPTH) + 32'($urandom_range(0, 1000))
                                             : 32'($urandom_range(0, 4*DEPTH-1));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            k = $urandom_range(0, 3);
            rsp_ready[0] = (k == 0);
            issue(0, 1'($urandom), a, sz, 1'($urandom), $urandom);
            repeat (k) @(posedge clk);
            #1;
            rsp_ready[0] = 1'b1;
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
